// File: rtl/cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// cpu_mem_responder
//
// Memory-side responder for the CPU's instruction-fetch port (pc) and
// load/store port (ldst). Both ports share a single DEPTH x 16-bit word array.
// Every accepted request completes with a fixed one-cycle read latency and no
// stall. Misaligned (addr[0]=1) and out-of-range (word index >= DEPTH)
// accesses raise sticky error flags. The access itself still completes.
//
// Optional feature, selected by the macro MEM_RESP_CLEAR_EN:
//   defined   - a post-reset clear engine zeroes the array one word per cycle.
//               o_init_busy is high for DEPTH cycles after reset release, and
//               requests are ignored while it is high.
//   undefined - no clear engine. o_init_busy is tied low, and the array
//               contents survive reset.
//
// Parameters:
//   DEPTH  array size in 16-bit words (power of two, 2..32768)
//   AW     word-index width, derived from DEPTH
//
// Ports:
//   clk               clock, rising edge
//   reset             asynchronous, active-low reset
//   i_pc_addr         fetch byte address (word index = addr[15:1])
//   i_pc_rd           fetch read strobe
//   o_pc_rddata       registered fetch data
//   i_ldst_addr       load/store byte address (word index = addr[15:1])
//   i_ldst_rd         load strobe
//   i_ldst_wr         store strobe (takes priority over i_ldst_rd)
//   i_ldst_wrdata     store data
//   o_ldst_rddata     registered load data
//   o_init_busy       clear engine running; requests are ignored
//   o_err_misaligned  sticky: accepted access with addr[0]=1
//   i_err_clr         synchronous clear of both error flags (a new event wins)
//   o_err_range       sticky: accepted access with word index >= DEPTH
// ---------------------------------------------------------------------------
module cpu_mem_responder #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_pc_addr,
    input  logic        i_pc_rd,
    output logic [15:0] o_pc_rddata,
    input  logic [15:0] i_ldst_addr,
    input  logic        i_ldst_rd,
    input  logic        i_ldst_wr,
    input  logic [15:0] i_ldst_wrdata,
    output logic [15:0] o_ldst_rddata,
    output logic        o_init_busy,
    output logic        o_err_misaligned,
    input  logic        i_err_clr,
    output logic        o_err_range
);

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    // The word array has no reset. Its contents are changed only by stores
    // and by the clear engine.
    logic [15:0] mem [DEPTH];

    logic        busy;
    logic        clear_we;
    logic [AW-1:0] clear_idx;

    // ------------------------------------------------------------------
    // Optional clear engine
    // ------------------------------------------------------------------
`ifdef MEM_RESP_CLEAR_EN
    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t        state_reg;
    logic [AW-1:0] clr_cnt_reg;
    logic          busy_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
            busy_reg    <= 1'b1;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    if (clr_cnt_reg == AW'(DEPTH - 1)) begin
                        state_reg <= ST_READY;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_READY;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // The engine also writes word 0 while reset is held. This is harmless
    // because the whole array is cleared again after release.
    assign busy      = busy_reg;
    assign clear_we  = (state_reg == ST_CLEAR);
    assign clear_idx = clr_cnt_reg;
`else
    assign busy      = 1'b0;
    assign clear_we  = 1'b0;
    assign clear_idx = '0;
`endif

    assign o_init_busy = busy;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [AW-1:0] pc_idx;
    logic [AW-1:0] ldst_idx;
    logic          pc_in_range;
    logic          ldst_in_range;
    logic          pc_acc;
    logic          ld_acc;
    logic          st_acc;
    logic          ldst_acc;
    logic          st_hits_pc;

    // addr[0] only selects the byte, so it is dropped from the word index.
    assign pc_idx   = i_pc_addr[AW:1];
    assign ldst_idx = i_ldst_addr[AW:1];

    // Compare the full 15-bit word index against DEPTH. Upper address bits
    // must not alias back into the array.
    assign pc_in_range   = ({1'b0, i_pc_addr[15:1]}   < DEPTH_W);
    assign ldst_in_range = ({1'b0, i_ldst_addr[15:1]} < DEPTH_W);

    assign pc_acc   = i_pc_rd & ~busy;
    assign st_acc   = i_ldst_wr & ~busy;
    assign ld_acc   = i_ldst_rd & ~i_ldst_wr & ~busy;   // a store suppresses the load
    assign ldst_acc = (i_ldst_rd | i_ldst_wr) & ~busy;

    // A fetch in the same cycle as a store to the same in-range word sees
    // the new data (write-first).
    assign st_hits_pc = st_acc & ldst_in_range & pc_in_range & (pc_idx == ldst_idx);

    // ------------------------------------------------------------------
    // Array write port (clear engine or store)
    // ------------------------------------------------------------------
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ldst_idx;
        mem_wdata = i_ldst_wrdata;
        if (clear_we) begin
            mem_we    = 1'b1;
            mem_waddr = clear_idx;
            mem_wdata = 16'h0000;
        end else if (st_acc && ldst_in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Registered read ports. Each register holds its value when no read is
    // accepted.
    // ------------------------------------------------------------------
    logic [15:0] pc_rddata_reg;
    logic [15:0] ldst_rddata_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_rddata_reg   <= 16'h0000;
            ldst_rddata_reg <= 16'h0000;
        end else begin
            if (pc_acc) begin
                if (!pc_in_range)
                    pc_rddata_reg <= 16'h0000;
                else if (st_hits_pc)
                    pc_rddata_reg <= i_ldst_wrdata;
                else
                    pc_rddata_reg <= mem[pc_idx];
            end
            if (ld_acc) begin
                ldst_rddata_reg <= ldst_in_range ? mem[ldst_idx] : 16'h0000;
            end
        end
    end

    assign o_pc_rddata   = pc_rddata_reg;
    assign o_ldst_rddata = ldst_rddata_reg;

    // ------------------------------------------------------------------
    // Sticky error flags. A new event has priority over i_err_clr.
    // ------------------------------------------------------------------
    logic mis_event;
    logic rng_event;
    logic err_mis_reg;
    logic err_rng_reg;

    assign mis_event = (pc_acc & i_pc_addr[0]) | (ldst_acc & i_ldst_addr[0]);
    assign rng_event = (pc_acc & ~pc_in_range) | (ldst_acc & ~ldst_in_range);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_mis_reg <= 1'b0;
            err_rng_reg <= 1'b0;
        end else begin
            if (mis_event)
                err_mis_reg <= 1'b1;
            else if (i_err_clr)
                err_mis_reg <= 1'b0;

            if (rng_event)
                err_rng_reg <= 1'b1;
            else if (i_err_clr)
                err_rng_reg <= 1'b0;
        end
    end

    assign o_err_misaligned = err_mis_reg;
    assign o_err_range      = err_rng_reg;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_responder
//
// Directed, table-driven bench for cpu_mem_responder with DEPTH=16.
// Each vector row drives one cycle of requests and lists the outputs expected
// in the following cycle. Hand-written sequences cover reset values, the
// clear-engine timing (when MEM_RESP_CLEAR_EN is defined), asynchronous reset
// in the middle of service, and reset in the middle of the clear.
// ---------------------------------------------------------------------------
module tb_cpu_mem_responder;

    localparam int DEPTH = 16;

`ifdef MEM_RESP_CLEAR_EN
    localparam int          EXP_BUSY   = DEPTH;
    localparam logic        EXP_BUSY0  = 1'b1;
    localparam logic [15:0] EXP_RETAIN = 16'h0000;   // array cleared on reset
`else
    localparam int          EXP_BUSY   = 0;
    localparam logic        EXP_BUSY0  = 1'b0;
    localparam logic [15:0] EXP_RETAIN = 16'h7777;   // array survives reset
`endif

    logic        clk;
    logic        reset;
    logic [15:0] i_pc_addr;
    logic        i_pc_rd;
    logic [15:0] o_pc_rddata;
    logic [15:0] i_ldst_addr;
    logic        i_ldst_rd;
    logic        i_ldst_wr;
    logic [15:0] i_ldst_wrdata;
    logic [15:0] o_ldst_rddata;
    logic        o_init_busy;
    logic        o_err_misaligned;
    logic        i_err_clr;
    logic        o_err_range;

    int tests_run = 0;
    int tests_failed = 0;

    cpu_mem_responder #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_pc_addr        (i_pc_addr),
        .i_pc_rd          (i_pc_rd),
        .o_pc_rddata      (o_pc_rddata),
        .i_ldst_addr      (i_ldst_addr),
        .i_ldst_rd        (i_ldst_rd),
        .i_ldst_wr        (i_ldst_wr),
        .i_ldst_wrdata    (i_ldst_wrdata),
        .o_ldst_rddata    (o_ldst_rddata),
        .o_init_busy      (o_init_busy),
        .o_err_misaligned (o_err_misaligned),
        .i_err_clr        (i_err_clr),
        .o_err_range      (o_err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pr;
        logic [15:0] pa;
        logic        lr;
        logic        lw;
        logic [15:0] la;
        logic [15:0] wd;
        logic        clr;
        logic [15:0] e_pc;
        logic [15:0] e_ld;
        logic        e_mis;
        logic        e_rng;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle();
        i_pc_rd = 1'b0; i_pc_addr = 16'h0;
        i_ldst_rd = 1'b0; i_ldst_wr = 1'b0; i_ldst_addr = 16'h0; i_ldst_wrdata = 16'h0;
        i_err_clr = 1'b0;
    endtask

    // Counts the cycles o_init_busy stays high, bounded to 100 cycles.
    task automatic count_busy(output int n);
        n = 0;
        while (o_init_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic apply(input int k);
        vec_t v;
        v = vecs[k];
        @(negedge clk);
        i_pc_rd = v.pr; i_pc_addr = v.pa;
        i_ldst_rd = v.lr; i_ldst_wr = v.lw; i_ldst_addr = v.la; i_ldst_wrdata = v.wd;
        i_err_clr = v.clr;
        @(posedge clk); #1;
        check("pc_rddata", k, o_pc_rddata, v.e_pc);
        check("ldst_rddata", k, o_ldst_rddata, v.e_ld);
        check("err_misaligned", k, 16'(o_err_misaligned), 16'(v.e_mis));
        check("err_range", k, 16'(o_err_range), 16'(v.e_rng));
        $display("[TB] vec %0d pc=%h ld=%h mis=%0b rng=%0b", k, o_pc_rddata, o_ldst_rddata,
                 o_err_misaligned, o_err_range);
    endtask

    initial begin
        int n;
        //           pr  pa        lr  lw  la        wd        clr  e_pc      e_ld      mis  rng
        vecs[0]  = '{0, 16'h0000, 0, 1, 16'h0000, 16'h5A5A, 0, 16'h0000, 16'h0000, 0, 0};
        vecs[1]  = '{0, 16'h0000, 0, 1, 16'h0010, 16'hBEEF, 0, 16'h0000, 16'h0000, 0, 0};
        vecs[2]  = '{0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 16'hBEEF, 0, 0};
        vecs[3]  = '{0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h5A5A, 0, 0};
        vecs[4]  = '{1, 16'h0014, 0, 1, 16'h0014, 16'h1234, 0, 16'h1234, 16'h5A5A, 0, 0};
        vecs[5]  = '{1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h5A5A, 16'h5A5A, 0, 0};
        vecs[6]  = '{0, 16'h0000, 1, 0, 16'h0040, 16'h0000, 0, 16'h5A5A, 16'h0000, 0, 1};
        vecs[7]  = '{0, 16'h0000, 0, 1, 16'h0040, 16'hDEAD, 0, 16'h5A5A, 16'h0000, 0, 1};
        vecs[8]  = '{0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 16'h5A5A, 16'h5A5A, 0, 1};
        vecs[9]  = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'h5A5A, 16'h5A5A, 0, 0};
        vecs[10] = '{1, 16'h0011, 0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 16'h5A5A, 1, 0};
        vecs[11] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 16'h5A5A, 0, 0};
        vecs[12] = '{0, 16'h0000, 1, 0, 16'h0001, 16'h0000, 1, 16'hBEEF, 16'h5A5A, 1, 0};
        vecs[13] = '{0, 16'h0000, 0, 1, 16'h0002, 16'h0101, 1, 16'hBEEF, 16'h5A5A, 0, 0};
        vecs[14] = '{0, 16'h0000, 1, 1, 16'h0010, 16'h7777, 0, 16'hBEEF, 16'h5A5A, 0, 0};
        vecs[15] = '{0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 16'hBEEF, 16'h7777, 0, 0};
        vecs[16] = '{1, 16'h0002, 1, 0, 16'h0002, 16'h0000, 0, 16'h0101, 16'h0101, 0, 0};
        vecs[17] = '{0, 16'h0000, 0, 1, 16'h0003, 16'h2222, 0, 16'h0101, 16'h0101, 1, 0};
        vecs[18] = '{0, 16'h0000, 1, 0, 16'h0002, 16'h0000, 0, 16'h0101, 16'h2222, 1, 0};
        vecs[19] = '{1, 16'h0020, 0, 1, 16'h0020, 16'h3333, 0, 16'h0000, 16'h2222, 1, 1};
        vecs[20] = '{1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h5A5A, 16'h2222, 1, 1};
        vecs[21] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h5A5A, 16'h2222, 1, 1};
        vecs[22] = '{1, 16'hFFFE, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h2222, 0, 1};
        vecs[23] = '{0, 16'h0000, 0, 1, 16'h001E, 16'h0F0F, 0, 16'h0000, 16'h2222, 0, 1};
        vecs[24] = '{0, 16'h0000, 1, 0, 16'h001F, 16'h0000, 0, 16'h0000, 16'h0F0F, 1, 1};
        vecs[25] = '{1, 16'h0014, 0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 16'h0F0F, 1, 1};
        vecs[26] = '{1, 16'h0021, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0F0F, 1, 1};
        vecs[27] = '{1, 16'h001E, 0, 1, 16'h001E, 16'hAAAA, 0, 16'hAAAA, 16'h0F0F, 1, 1};
        vecs[28] = '{1, 16'h001E, 1, 0, 16'h001E, 16'h0000, 0, 16'hAAAA, 16'hAAAA, 1, 1};

        idle();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pc", 0, o_pc_rddata, 16'h0000);
        check("reset_ld", 0, o_ldst_rddata, 16'h0000);
        check("reset_mis", 0, 16'(o_err_misaligned), 16'h0);
        check("reset_rng", 0, 16'(o_err_range), 16'h0);
        check("reset_busy", 0, 16'(o_init_busy), 16'(EXP_BUSY0));
        $display("[TB] reset: pc=%h ld=%h busy=%0b", o_pc_rddata, o_ldst_rddata, o_init_busy);

        // Release reset and measure the busy window.
        @(negedge clk);
        reset = 1'b1;
`ifdef MEM_RESP_CLEAR_EN
        // This load is issued while busy, so it must be ignored.
        i_ldst_rd = 1'b1; i_ldst_addr = 16'h0006;
        @(posedge clk); #1;
        check("busy_load", 0, o_ldst_rddata, 16'h0000);
        $display("[TB] load during busy: ld=%h", o_ldst_rddata);
        idle();
        count_busy(n);
        n = n + 1;
`else
        count_busy(n);
`endif
        check("busy_cycles", 0, 16'(n), 16'(EXP_BUSY));
        $display("[TB] busy cycles after reset: %0d", n);

`ifdef MEM_RESP_CLEAR_EN
        @(negedge clk);
        i_ldst_rd = 1'b1; i_ldst_addr = 16'h0006;
        @(posedge clk); #1;
        check("post_clear_load", 0, o_ldst_rddata, 16'h0000);
        check("post_clear_busy", 0, 16'(o_init_busy), 16'h0);
        $display("[TB] load after clear: ld=%h", o_ldst_rddata);
        idle();
`endif

        for (int k = 0; k < NVEC; k++) begin
            apply(k);
        end
        idle();

        // Asynchronous reset in the middle of service. The outputs must clear
        // before any clock edge.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_pc", 0, o_pc_rddata, 16'h0000);
        check("async_ld", 0, o_ldst_rddata, 16'h0000);
        check("async_mis", 0, 16'(o_err_misaligned), 16'h0);
        check("async_rng", 0, 16'(o_err_range), 16'h0);
        $display("[TB] async reset: pc=%h ld=%h mis=%0b rng=%0b", o_pc_rddata, o_ldst_rddata,
                 o_err_misaligned, o_err_range);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

`ifdef MEM_RESP_CLEAR_EN
        // Reset mid-clear at clear cycle 7. The clear must restart from word 0.
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midclear_busy", 0, 16'(o_init_busy), 16'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #4;
`endif
        count_busy(n);
        check("busy_cycles_2", 0, 16'(n), 16'(EXP_BUSY));
        $display("[TB] busy cycles after second reset: %0d", n);

        // Check what word 8 holds after reset: cleared with the engine,
        // retained without it.
        @(negedge clk);
        i_ldst_rd = 1'b1; i_ldst_addr = 16'h0010;
        @(posedge clk); #1;
        check("after_reset_word8", 0, o_ldst_rddata, EXP_RETAIN);
        $display("[TB] word 8 after reset: ld=%h", o_ldst_rddata);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global timeout so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
